psum_accum_quant: RTL and testbench

Consumer of the adder-tree outputs. Accumulates the four 22-bit lane partial sums over a programmable number of input-channel groups, then requantizes each lane to signed 8 bits with round-half-up shift and saturation. Packs the four lanes into one 32-bit word for the writeback stage, using a valid/ready output handshake. Sits between the adder tree and the output buffer writer.

---
 rtl/psum_accum_quant_pkg.sv | 38 +++
 rtl/psum_accum_quant_requant_lane.sv | 34 +++
 rtl/psum_accum_quant.sv | 173 +++++++++++++++++
 tb/tb_psum_accum_quant.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_quant_pkg.sv
// Shared definitions for the partial-sum accumulate / requantize block.
// Holds the data-path widths, the FSM state encoding, the accumulator
// and quantizer saturation limits, and the saturating lane add.
package psum_accum_quant_pkg;

  localparam int IN_W      = 22;  // lane partial-sum width
  localparam int ACC_W     = 26;  // accumulator width
  localparam int OUT_W     = 8;   // quantized lane width
  localparam int NUM_LANES = 4;
  localparam int GRP_W     = 5;
  localparam int PIX_W     = 16;
  localparam int SH_W      = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // Symmetric accumulator limits +/-(2^(ACC_W-1)-1), held one bit wider
  // so that the pre-saturation sum can be compared directly.
  localparam logic signed [ACC_W:0] ACC_SAT_HI = (ACC_W+1)'((2**(ACC_W-1)) - 1);
  localparam logic signed [ACC_W:0] ACC_SAT_LO = -ACC_SAT_HI;

  // Quantizer clamp limits [-128, 127] at the same width as the requant sum.
  localparam logic signed [ACC_W:0] Q_HI = (ACC_W+1)'((2**(OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] Q_LO = ~Q_HI;

  // acc + sext(ps), saturated to the accumulator limits.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [IN_W-1:0]  ps);
    logic signed [ACC_W:0] s;
    s = $signed({acc[ACC_W-1], acc}) + $signed({{(ACC_W+1-IN_W){ps[IN_W-1]}}, ps});
    if (s > ACC_SAT_HI)      sat_add = ACC_SAT_HI[ACC_W-1:0];
    else if (s < ACC_SAT_LO) sat_add = ACC_SAT_LO[ACC_W-1:0];
    else                     sat_add = s[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/psum_accum_quant_requant_lane.sv
// requant_lane: one lane of the requantizer (combinational).
//   s_i     : signed accumulated lane sum (ACC_W)
//   shift_i : right shift amount
//   q_o     : signed OUT_W result
// Round-half-up: add 2^(shift-1) (nothing when shift is 0), arithmetic
// shift right, then clamp to the signed 8-bit range.
// Build option PSUM_RELU_EN: negative results become 0 before the clamp.
module requant_lane
  import psum_accum_quant_pkg::*;
(
  input  logic [ACC_W-1:0] s_i,
  input  logic [SH_W-1:0]  shift_i,
  output logic [OUT_W-1:0] q_o
);

  logic [ACC_W:0]        rnd;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] r;

  always_comb begin
    // (1 << shift) >> 1 yields 2^(shift-1), and 0 for shift == 0.
    rnd = ((ACC_W+1)'(1) << shift_i) >> 1;
    // One extra bit keeps max sum + max rounding term from wrapping.
    sum = $signed({s_i[ACC_W-1], s_i}) + $signed(rnd);
    r   = sum >>> shift_i;
`ifdef PSUM_RELU_EN
    if (r[ACC_W]) r = '0;
`endif
    if (r > Q_HI)      q_o = Q_HI[OUT_W-1:0];
    else if (r < Q_LO) q_o = Q_LO[OUT_W-1:0];
    else               q_o = r[OUT_W-1:0];
  end

endmodule

// File: rtl/psum_accum_quant.sv
// psum_accum_quant: accumulates four lane partial sums over grp_num
// input-channel groups, requantizes each lane to signed 8 bits and
// presents the packed word on a valid/ready output.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   iStart              : tile start (accepted in IDLE only)
//   iGrpNum/iPixNum     : groups per pixel / pixels per tile (0 means 1)
//   iShift              : requant right shift
//   vld_i, iPsum0..3    : partial-sum beat (no upstream stall)
//   oData, oVld, iRdy   : packed output word handshake, lane k at [8k+7:8k]
//   oBusy               : FSM active or stage register valid
//   oDone               : pulse when the tile's last pixel reaches the
//                         output register (loaded or dropped)
//   oOvf                : sticky, a result was dropped under backpressure
// Build option PSUM_RELU_EN: clamp requant results to [0,127].
// Pipeline: accumulate -> S stage register -> requant -> output register.
module psum_accum_quant
  import psum_accum_quant_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iStart,
  input  logic [GRP_W-1:0]     iGrpNum,
  input  logic [PIX_W-1:0]     iPixNum,
  input  logic [SH_W-1:0]      iShift,
  input  logic                 vld_i,
  input  logic [IN_W-1:0]      iPsum0,
  input  logic [IN_W-1:0]      iPsum1,
  input  logic [IN_W-1:0]      iPsum2,
  input  logic [IN_W-1:0]      iPsum3,
  output logic [NUM_LANES*OUT_W-1:0] oData,
  output logic                 oVld,
  input  logic                 iRdy,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oOvf
);

  state_e                              state_q, state_d;
  logic [GRP_W-1:0]                    grp_num_q, grp_num_d;
  logic [PIX_W-1:0]                    pix_num_q, pix_num_d;
  logic [SH_W-1:0]                     shift_q, shift_d;
  logic [GRP_W-1:0]                    grp_cnt_q, grp_cnt_d;
  logic [PIX_W-1:0]                    pix_cnt_q, pix_cnt_d;
  logic [NUM_LANES-1:0][ACC_W-1:0]     acc_q, acc_d;
  logic [NUM_LANES-1:0][ACC_W-1:0]     s_q, s_d;
  logic                                s_vld_q, s_vld_d;
  logic                                s_last_q, s_last_d;
  logic [NUM_LANES-1:0][OUT_W-1:0]     odata_q, odata_d;
  logic                                ovld_q, ovld_d;
  logic                                odone_q, odone_d;
  logic                                ovf_q, ovf_d;

  logic [NUM_LANES-1:0][IN_W-1:0]      psum;
  logic [NUM_LANES-1:0][ACC_W-1:0]     lane_sum;
  logic [NUM_LANES-1:0][OUT_W-1:0]     qword;
  logic                                start_acc;
  logic                                out_load;
  logic                                out_drop;

  assign psum = {iPsum3, iPsum2, iPsum1, iPsum0};

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) lane_sum[k] = sat_add(acc_q[k], psum[k]);
  end

  genvar gk;
  generate
    for (gk = 0; gk < NUM_LANES; gk++) begin : g_rq
      requant_lane u_rq (
        .s_i     (s_q[gk]),
        .shift_i (shift_q),
        .q_o     (qword[gk])
      );
    end
  endgenerate

  assign start_acc = (state_q == ST_IDLE) && iStart;
  assign out_load  = s_vld_q && (!ovld_q || iRdy);
  assign out_drop  = s_vld_q && ovld_q && !iRdy;

  always_comb begin
    state_d   = state_q;
    grp_num_d = grp_num_q;
    pix_num_d = pix_num_q;
    shift_d   = shift_q;
    grp_cnt_d = grp_cnt_q;
    pix_cnt_d = pix_cnt_q;
    acc_d     = acc_q;
    s_d       = s_q;
    s_vld_d   = 1'b0;
    s_last_d  = 1'b0;

    if (start_acc) begin
      state_d   = ST_ACC;
      grp_num_d = (iGrpNum == '0) ? GRP_W'(1) : iGrpNum;
      pix_num_d = (iPixNum == '0) ? PIX_W'(1) : iPixNum;
      shift_d   = iShift;
      grp_cnt_d = '0;
      pix_cnt_d = '0;
      acc_d     = '0;
    end else if (state_q == ST_ACC && vld_i) begin
      if (grp_cnt_q == grp_num_q - GRP_W'(1)) begin
        // Final group: hand the sum to S and restart accumulation in the
        // same cycle so consecutive pixels stream without a bubble.
        s_d       = lane_sum;
        s_vld_d   = 1'b1;
        acc_d     = '0;
        grp_cnt_d = '0;
        pix_cnt_d = pix_cnt_q + PIX_W'(1);
        if (pix_cnt_q == pix_num_q - PIX_W'(1)) begin
          s_last_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end else begin
        acc_d     = lane_sum;
        grp_cnt_d = grp_cnt_q + GRP_W'(1);
      end
    end
  end

  always_comb begin
    odata_d = out_load ? qword : odata_q;
    if (out_load)  ovld_d = 1'b1;
    else if (iRdy) ovld_d = 1'b0;
    else           ovld_d = ovld_q;
    odone_d = s_vld_q && s_last_q;
    // A drop in the same cycle as a new start still flags, so the loss
    // is never silently hidden.
    ovf_d   = out_drop || (ovf_q && !start_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grp_num_q <= '0;
      pix_num_q <= '0;
      shift_q   <= '0;
      grp_cnt_q <= '0;
      pix_cnt_q <= '0;
      acc_q     <= '0;
      s_q       <= '0;
      s_vld_q   <= 1'b0;
      s_last_q  <= 1'b0;
      odata_q   <= '0;
      ovld_q    <= 1'b0;
      odone_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grp_num_q <= grp_num_d;
      pix_num_q <= pix_num_d;
      shift_q   <= shift_d;
      grp_cnt_q <= grp_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      acc_q     <= acc_d;
      s_q       <= s_d;
      s_vld_q   <= s_vld_d;
      s_last_q  <= s_last_d;
      odata_q   <= odata_d;
      ovld_q    <= ovld_d;
      odone_q   <= odone_d;
      ovf_q     <= ovf_d;
    end
  end

  assign oData = odata_q;
  assign oVld  = ovld_q;
  assign oDone = odone_q;
  assign oOvf  = ovf_q;
  assign oBusy = (state_q != ST_IDLE) || s_vld_q;

endmodule

// File: tb/tb_psum_accum_quant.sv
// Directed bench for psum_accum_quant with hand-computed expected words.
module tb_psum_accum_quant;

  logic        clk = 1'b0;
  logic        rst;
  logic        iStart;
  logic [4:0]  iGrpNum;
  logic [15:0] iPixNum;
  logic [4:0]  iShift;
  logic        vld_i;
  logic [21:0] iPsum0, iPsum1, iPsum2, iPsum3;
  logic [31:0] oData;
  logic        oVld, iRdy, oBusy, oDone, oOvf;

  int nvec = 0;
  int nfail = 0;

  psum_accum_quant dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iGrpNum(iGrpNum), .iPixNum(iPixNum),
    .iShift(iShift), .vld_i(vld_i), .iPsum0(iPsum0), .iPsum1(iPsum1),
    .iPsum2(iPsum2), .iPsum3(iPsum3), .oData(oData), .oVld(oVld), .iRdy(iRdy),
    .oBusy(oBusy), .oDone(oDone), .oOvf(oOvf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ps(input int a, input int b, input int c, input int d);
    logic [31:0] t;
    t = a; iPsum0 = t[21:0];
    t = b; iPsum1 = t[21:0];
    t = c; iPsum2 = t[21:0];
    t = d; iPsum3 = t[21:0];
  endtask

  task automatic start(input int grp, input int pix, input int sh);
    logic [31:0] t;
    t = grp; iGrpNum = t[4:0];
    t = pix; iPixNum = t[15:0];
    t = sh;  iShift  = t[4:0];
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  initial begin
    rst = 1'b1; iStart = 1'b0; iGrpNum = '0; iPixNum = '0; iShift = '0;
    vld_i = 1'b0; iRdy = 1'b1;
    set_ps(0, 0, 0, 0);
    tick(); tick();
    chk("rst_oData", oData, 32'h0);
    chk("rst_oVld", {31'd0, oVld}, 32'd0);
    chk("rst_oBusy", {31'd0, oBusy}, 32'd0);
    chk("rst_oDone", {31'd0, oDone}, 32'd0);
    chk("rst_oOvf", {31'd0, oOvf}, 32'd0);
    rst = 1'b0;

    // Single group, shift 0: {5,-3,127,200} -> {5,-3,127,127}
    start(1, 1, 0);
    chk("t1_busy_acc", {31'd0, oBusy}, 32'd1);
    vld_i = 1'b1; set_ps(5, -3, 127, 200);
    tick();
    vld_i = 1'b0;
    chk("t1_vld_T1", {31'd0, oVld}, 32'd0);
    chk("t1_busy_s", {31'd0, oBusy}, 32'd1);
    tick();
    chk("t1_vld_T2", {31'd0, oVld}, 32'd1);
    chk("t1_data", oData, 32'h7F7F_FD05);
    chk("t1_done", {31'd0, oDone}, 32'd1);
    chk("t1_busy_end", {31'd0, oBusy}, 32'd0);
    tick();
    chk("t1_vld_acc", {31'd0, oVld}, 32'd0);
    chk("t1_done_pulse", {31'd0, oDone}, 32'd0);

    // vld_i in IDLE is ignored
    vld_i = 1'b1; set_ps(9, 9, 9, 9);
    tick(); vld_i = 1'b0; tick();
    chk("idle_vld_ign", {30'd0, oVld, oBusy}, 32'd0);

    // Three groups of 100, shift 2: (300+2)>>>2 = 75
    start(3, 1, 2);
    vld_i = 1'b1; set_ps(100, 100, 100, 100);
    tick(); tick(); tick();
    vld_i = 1'b0;
    chk("t2_no_early", {31'd0, oVld}, 32'd0);
    tick();
    chk("t2_vld", {31'd0, oVld}, 32'd1);
    chk("t2_data", oData, 32'h4B4B_4B4B);
    tick();
    chk("t2_single", {31'd0, oVld}, 32'd0);

    // Negative rounding, shift 2: {-6,7,-7,9} -> {-1,2,-2,2}
    start(1, 1, 2);
    vld_i = 1'b1; set_ps(-6, 7, -7, 9);
    tick(); vld_i = 1'b0; tick();
`ifdef PSUM_RELU_EN
    chk("t3_round", oData, 32'h0200_0200);
`else
    chk("t3_round", oData, 32'h02FE_02FF);
`endif
    tick();
    // Clamp, shift 0: {-1000,1000,-128,-129} -> {-128,127,-128,-128}
    start(1, 1, 0);
    vld_i = 1'b1; set_ps(-1000, 1000, -128, -129);
    tick(); vld_i = 1'b0; tick();
`ifdef PSUM_RELU_EN
    chk("t3_clamp", oData, 32'h0000_7F00);
`else
    chk("t3_clamp", oData, 32'h8080_7F80);
`endif
    tick();

    // Two pixels of two groups, back to back
    start(2, 2, 0);
    vld_i = 1'b1;
    set_ps(1, 1, 1, 1);     tick();
    set_ps(2, 2, 2, 2);     tick();
    set_ps(10, 10, 10, 10); tick();
    chk("t4_w0_vld", {31'd0, oVld}, 32'd1);
    chk("t4_w0_data", oData, 32'h0303_0303);
    chk("t4_w0_nodone", {31'd0, oDone}, 32'd0);
    set_ps(20, 20, 20, 20); tick();
    vld_i = 1'b0;
    chk("t4_gap", {31'd0, oVld}, 32'd0);
    chk("t4_busy_s", {31'd0, oBusy}, 32'd1);
    tick();
    chk("t4_w1_vld", {31'd0, oVld}, 32'd1);
    chk("t4_w1_data", oData, 32'h1E1E_1E1E);
    chk("t4_w1_done", {31'd0, oDone}, 32'd1);
    chk("t4_idle", {31'd0, oBusy}, 32'd0);
    tick();

    // Backpressure: second word dropped, first held
    iRdy = 1'b0;
    start(1, 2, 0);
    vld_i = 1'b1;
    set_ps(1, 1, 1, 1); tick();
    set_ps(2, 2, 2, 2); tick();
    vld_i = 1'b0;
    chk("t5_ovf_clear", {31'd0, oOvf}, 32'd0);
    tick();
    chk("t5_hold_data", oData, 32'h0101_0101);
    chk("t5_hold_vld", {31'd0, oVld}, 32'd1);
    chk("t5_ovf", {31'd0, oOvf}, 32'd1);
    chk("t5_done_drop", {31'd0, oDone}, 32'd1);
    tick();
    chk("t5_still_held", oData, 32'h0101_0101);
    iRdy = 1'b1;
    tick();
    chk("t5_handshake", {31'd0, oVld}, 32'd0);
    chk("t5_ovf_sticky", {31'd0, oOvf}, 32'd1);

    // Reset mid-tile
    start(3, 1, 0);
    chk("t6_ovf_cleared", {31'd0, oOvf}, 32'd0);
    vld_i = 1'b1; set_ps(50, 50, 50, 50); tick();
    vld_i = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_data", oData, 32'h0);
    chk("t6_rst_flags", {28'd0, oVld, oBusy, oDone, oOvf}, 32'd0);
    start(1, 1, 0);
    vld_i = 1'b1; set_ps(7, 7, 7, 7); tick();
    vld_i = 1'b0; tick();
    chk("t6_after_vld", {31'd0, oVld}, 32'd1);
    chk("t6_after_data", oData, 32'h0707_0707);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
